// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding and the
// mode/enable constants used across the execute stage.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    localparam logic SIGNED      = 1'b1;
    localparam logic UNSIGNED    = 1'b0;
    localparam logic ENABLED     = 1'b1;
    localparam logic RST_ENABLED = 1'b1;

endpackage

// File: rtl/seq_multiplier_mul_step.sv
// One CALC cycle of shift-add: adds up to STEP shifted copies of |a| into
// the accumulator, selected by the current low STEP bits of |b|.
module seq_multiplier_mul_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = 6
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [STEP-1:0]    b_bits,
    input  logic [SHW-1:0]     shift,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] base;
    logic [2*WIDTH-1:0] sum;

    always_comb begin
        base = {{WIDTH{1'b0}}, a_mag} << shift;
        sum  = acc;
        for (int i = 0; i < STEP; i++) begin
            if (b_bits[i]) begin
                sum = sum + (base << i);
            end
        end
        acc_next = sum;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier producing a 2*WIDTH-bit product as HI/LO.
// Signed operands are multiplied as magnitudes and the product negated in FIX.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mul_hi,
    output logic [WIDTH-1:0] mul_lo,
    output mul_state_e       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH / STEP + 1);
    localparam int SHW   = $clog2(2 * WIDTH);

    mul_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_step, fix_result;
    logic [WIDTH-1:0]   a_mag_q, b_shf_q, a_mag_d, b_mag_d;
    logic [SHW-1:0]     shift_q;
    logic [CNT_W-1:0]   count_q;
    logic               negate_q, negate_d;
    logic               capture, zero_op, go;

    // Handshake: start is accepted only in IDLE or DONE with cancel low; the
    // caller holds off while busy, and done pulses once when mul_hi/mul_lo are new.
    assign go      = (start == ENABLED) && (cancel != ENABLED);
    assign zero_op = (a == '0) || (b == '0);

    always_comb begin
        a_mag_d    = ((sign == SIGNED) && a[WIDTH-1]) ? -a : a;
        b_mag_d    = ((sign == SIGNED) && b[WIDTH-1]) ? -b : b;
        negate_d   = (sign == UNSIGNED) ? 1'b0 : (a[WIDTH-1] ^ b[WIDTH-1]);
        fix_result = negate_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset == RST_ENABLED) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    capture = 1'b1;
                    state_d = zero_op ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cancel == ENABLED) begin
                    state_d = IDLE;
                end else if (count_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = (cancel == ENABLED) ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    seq_multiplier_mul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SHW   (SHW)
    ) u_mul_step (
        .acc      (acc_q),
        .a_mag    (a_mag_q),
        .b_bits   (b_shf_q[STEP-1:0]),
        .shift    (shift_q),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset == RST_ENABLED) begin
            acc_q    <= '0;
            a_mag_q  <= '0;
            b_shf_q  <= '0;
            shift_q  <= '0;
            count_q  <= '0;
            negate_q <= 1'b0;
            mul_hi   <= '0;
            mul_lo   <= '0;
        end else if (capture) begin
            acc_q    <= '0;
            a_mag_q  <= a_mag_d;
            b_shf_q  <= b_mag_d;
            shift_q  <= '0;
            count_q  <= CNT_W'(WIDTH / STEP);
            negate_q <= negate_d;
            if (zero_op) begin
                mul_hi <= '0;
                mul_lo <= '0;
            end
        end else if (state_q == CALC && cancel != ENABLED) begin
            acc_q   <= acc_step;
            b_shf_q <= b_shf_q >> STEP;
            shift_q <= shift_q + SHW'(STEP);
            count_q <= count_q - CNT_W'(1);
        end else if (state_q == FIX && cancel != ENABLED) begin
            {mul_hi, mul_lo} <= fix_result;
        end
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised multi-cycle shift-add multiplier for the execute stage. It serves MULT/MULTU and the MUL family, and produces a 2*WIDTH-bit product as HI/LO halves.
- Replaces the single-cycle combinational multiplier so the critical path is cut. Operand width and bits retired per cycle are configurable.
- Has a start/busy/done handshake and a cancel input for pipeline flushes. The hazard unit stalls on busy.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- STEP, 1, multiplier bits retired per CALC cycle; must divide WIDTH exactly (legal values 1, 2, 4).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- sign  in  1  1 = signed (two's complement), 0 = unsigned; sampled with start
- cancel  in  1  flush; aborts any operation in progress
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- busy  out  1  1 in CALC and FIX
- done  out  1  one-cycle pulse; result valid
- mul_hi  out  WIDTH  upper half of product, registered
- mul_lo  out  WIDTH  lower half of product, registered

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE.
  - busy, done, mul_hi, mul_lo, accumulator, counter, negate flag and operand registers are all cleared to 0.
- States:
  - IDLE: start=1 and cancel=0 → capture operands. If a==0 or b==0, go to DONE with product 0. Otherwise go to CALC.
  - CALC: each edge adds STEP partial products of |a| selected by the low STEP bits of the shifted |b| into the accumulator. The counter decrements from WIDTH/STEP; when it reaches 0, go to FIX.
  - FIX: if the negate flag is set, take the two's complement of the 2*WIDTH accumulator. Load mul_hi/mul_lo. Go to DONE.
  - DONE: done=1 for exactly this cycle. If start=1 and cancel=0, capture new operands as in IDLE (back-to-back issue); otherwise go to IDLE.
- Operand capture:
  - Unsigned mode: operands are used unchanged and the negate flag is 0.
  - Signed mode: each negative operand is replaced by its two's complement, and negate = a[W-1]^b[W-1].
  - A most-negative operand (-2^(W-1)) becomes magnitude 2^(W-1), treated as unsigned; no overflow handling is needed.
- Latency, counted from the edge that samples start:
  - done is high after WIDTH/STEP + 2 edges; for WIDTH=32, STEP=1 that is 34 edges.
  - Zero-operand early-out: done is high after 1 edge.
  - busy is high from the capture edge until the edge that enters DONE.
- Handshake:
  - start while busy=1 is ignored; operands are not re-sampled.
  - a, b and sign may change freely after capture.
- Result registers:
  - mul_hi/mul_lo change only on the edge that enters DONE (or on reset).
  - They hold the last result indefinitely, including across cancel.
- Cancel:
  - In CALC or FIX, the next state is IDLE; done is not asserted and mul_hi/mul_lo are unchanged.
  - cancel=1 together with start=1 (in IDLE or DONE): cancel wins, nothing is captured, next state is IDLE.
  - cancel in DONE does not retract the done already being driven that cycle.
- Width rules:
  - The accumulator is 2*WIDTH bits and the shift is logical.
  - All arithmetic wraps modulo 2^(2*WIDTH).

Decomposition:
- Shared package / header:
  - state encodings (IDLE, CALC, FIX, DONE)
  - the SIGNED/UNSIGNED and ENABLED/RST_ENABLED constants already used by the execute stage
- One natural sub-module, mul_step: combinational STEP-bit partial-product accumulate.
  - inputs: accumulator, |a|, STEP bits of |b|, current shift
  - output: next accumulator
  - Instantiated once; the FSM, counter and sign handling stay in seq_multiplier.

Test Plan (WIDTH=32, STEP=1 unless stated):
1. Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, sign=0 → done at edge 34, hi=0xFFFFFFFE, lo=0x00000001; busy high for edges 1–33.
2. Signed: a=0xFFFFFFFD (-3), b=7, sign=1 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also a=b=0x80000000, sign=1 → hi=0x40000000, lo=0.
3. Zero early-out: a=0, b=0x12345678 → done after 1 edge, hi=lo=0; busy never asserted.
4. Cancel: start a=5, b=6; cancel at edge 10 → IDLE, no done pulse, hi/lo keep their previous values; a following start completes normally (30 → lo=0x1E).
5. Back-to-back and ignored start: start held high through busy → only the first operation runs; start in DONE → new operation begins with no IDLE cycle.
6. Reset mid-CALC: assert reset asynchronously between edges → outputs 0 immediately. Also run STEP=4 with test 1's operands → done at edge 10, same result.
